anim_pattern_gen: RTL and testbench

ANIM_PATTERN_GEN -- requirements
Module: anim_pattern_gen

---
 rtl/anim_pattern_gen.sv | 222 ++++++++++++++++++++++
 tb/tb_anim_pattern_gen.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/anim_pattern_gen.sv
// rtl/anim_pattern_gen.sv - animated video test-pattern generator locked to incoming syncs
//
// Regenerates pixel position from i_VSync/i_HSync timing and paints one of ten
// patterns, selected manually (i_Pattern) or cycled automatically (i_Auto).
// Ports:
//   i_Clk, i_Rst_L                pixel clock, asynchronous active-low reset
//   i_Pattern, i_Auto             manual pattern request / auto-cycle enable
//   i_HSync, i_VSync              incoming syncs, active-high
//   o_HSync, o_VSync              syncs delayed two clocks to line up with video
//   o_Red/Grn/Blu_Video           pixel colour, VIDEO_WIDTH bits per channel
//   o_Active_Pattern              pattern currently on screen
//   o_Frame_Start                 one-cycle pulse per detected frame start

module anim_pattern_gen #(
    parameter int VIDEO_WIDTH  = 3,
    parameter int TOTAL_COLS   = 800,
    parameter int TOTAL_ROWS   = 525,
    parameter int ACTIVE_COLS  = 640,
    parameter int ACTIVE_ROWS  = 480,
    parameter int BOX_SIZE     = 32,
    parameter int CYCLE_FRAMES = 120
) (
    input  logic                   i_Clk,
    input  logic                   i_Rst_L,
    input  logic [3:0]             i_Pattern,
    input  logic                   i_Auto,
    input  logic                   i_HSync,
    input  logic                   i_VSync,
    output logic                   o_HSync,
    output logic                   o_VSync,
    output logic [VIDEO_WIDTH-1:0] o_Red_Video,
    output logic [VIDEO_WIDTH-1:0] o_Grn_Video,
    output logic [VIDEO_WIDTH-1:0] o_Blu_Video,
    output logic [3:0]             o_Active_Pattern,
    output logic                   o_Frame_Start
);

    localparam int CW    = $clog2(TOTAL_COLS);
    localparam int RW    = $clog2(TOTAL_ROWS);
    localparam int TW    = $clog2(CYCLE_FRAMES + 1);
    localparam int BAR_W = ACTIVE_COLS / 8;

    localparam logic [CW-1:0] COL_LAST  = CW'(TOTAL_COLS - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(TOTAL_ROWS - 1);
    localparam logic [CW-1:0] ACT_C     = CW'(ACTIVE_COLS);
    localparam logic [RW-1:0] ACT_R     = RW'(ACTIVE_ROWS);
    localparam logic [CW-1:0] COL_EDGE1 = CW'(ACTIVE_COLS - 2);
    localparam logic [CW-1:0] COL_EDGE0 = CW'(ACTIVE_COLS - 1);
    localparam logic [RW-1:0] ROW_EDGE1 = RW'(ACTIVE_ROWS - 2);
    localparam logic [RW-1:0] ROW_EDGE0 = RW'(ACTIVE_ROWS - 1);
    localparam logic [CW-1:0] BOX_X_MAX = CW'(ACTIVE_COLS - BOX_SIZE);
    localparam logic [RW-1:0] BOX_Y_MAX = RW'(ACTIVE_ROWS - BOX_SIZE);
    localparam logic [TW-1:0] TALLY_END = TW'(CYCLE_FRAMES);
    localparam logic [VIDEO_WIDTH-1:0] ONES = '1;

    logic                   vsync_q;
    logic                   frame_start;
    logic                   hsync_d1, vsync_d1;
    logic [CW-1:0]          col;
    logic [RW-1:0]          row;
    logic [7:0]             frame_count;
    logic [TW-1:0]          tally;
    logic [TW-1:0]          tally_inc;
    logic                   auto_q;
    logic [CW-1:0]          box_x, box_x_nx;
    logic [RW-1:0]          box_y, box_y_nx;
    logic                   dir_x, dir_y;
    logic                   in_active, on_border, in_box;
    logic [2:0]             bar, scroll_bar;
    logic [31:0]            scroll_col;
    logic [VIDEO_WIDTH-1:0] grey;
    logic [VIDEO_WIDTH-1:0] red_d, grn_d, blu_d;

    function automatic logic [3:0] next_pattern(input logic [3:0] p);
        return (p == 4'd0 || p > 4'd8) ? 4'd1 : p + 4'd1;
    endfunction

    assign frame_start = i_VSync & ~vsync_q;

    // A tally left over from an earlier auto period is ignored on re-entry.
    assign tally_inc = (auto_q ? tally : '0) + 1'b1;

    assign box_x_nx = dir_x ? box_x + 1'b1 : box_x - 1'b1;
    assign box_y_nx = dir_y ? box_y + 1'b1 : box_y - 1'b1;

    // Sync delay line and frame-start detection.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            vsync_q       <= 1'b0;
            hsync_d1      <= 1'b0;
            vsync_d1      <= 1'b0;
            o_HSync       <= 1'b0;
            o_VSync       <= 1'b0;
            o_Frame_Start <= 1'b0;
        end else begin
            vsync_q       <= i_VSync;
            hsync_d1      <= i_HSync;
            vsync_d1      <= i_VSync;
            o_HSync       <= hsync_d1;
            o_VSync       <= vsync_d1;
            o_Frame_Start <= frame_start;
        end
    end

    // Pixel position counters.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            col <= '0;
            row <= '0;
        end else if (frame_start) begin
            col <= '0;
            row <= '0;
        end else if (col == COL_LAST) begin
            col <= '0;
            row <= (row == ROW_LAST) ? '0 : row + 1'b1;
        end else begin
            col <= col + 1'b1;
        end
    end

    // Per-frame state: pattern selection, auto tally, animation state.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            o_Active_Pattern <= '0;
            tally            <= '0;
            auto_q           <= 1'b0;
            frame_count      <= '0;
            box_x            <= '0;
            box_y            <= '0;
            dir_x            <= 1'b1;
            dir_y            <= 1'b1;
        end else if (frame_start) begin
            auto_q      <= i_Auto;
            frame_count <= frame_count + 1'b1;
            if (i_Auto) begin
                if (tally_inc == TALLY_END) begin
                    tally            <= '0;
                    o_Active_Pattern <= next_pattern(o_Active_Pattern);
                end else begin
                    tally <= tally_inc;
                end
            end else begin
                tally            <= '0;
                o_Active_Pattern <= i_Pattern;
            end
            box_x <= box_x_nx;
            box_y <= box_y_nx;
            if (box_x_nx == '0 || box_x_nx == BOX_X_MAX) dir_x <= ~dir_x;
            if (box_y_nx == '0 || box_y_nx == BOX_Y_MAX) dir_y <= ~dir_y;
        end
    end

    // Pattern geometry from the current position.
    assign in_active  = (col < ACT_C) && (row < ACT_R);
    assign on_border  = (row <= RW'(1)) || (row == ROW_EDGE1) || (row == ROW_EDGE0) ||
                        (col <= CW'(1)) || (col == COL_EDGE1) || (col == COL_EDGE0);
    assign in_box     = (col >= box_x) && ({1'b0, col} < {1'b0, box_x} + (CW+1)'(BOX_SIZE)) &&
                        (row >= box_y) && ({1'b0, row} < {1'b0, box_y} + (RW+1)'(BOX_SIZE));
    assign bar        = 3'(32'(col) / BAR_W);
    assign scroll_col = (32'(col) + 32'({frame_count, 1'b0})) % ACTIVE_COLS;
    assign scroll_bar = 3'(scroll_col / BAR_W);
    assign grey       = VIDEO_WIDTH'((32'(col) << VIDEO_WIDTH) / ACTIVE_COLS);

    always_comb begin
        red_d = '0;
        grn_d = '0;
        blu_d = '0;
        if (in_active) begin
            case (o_Active_Pattern)
                4'd1: red_d = ONES;
                4'd2: grn_d = ONES;
                4'd3: blu_d = ONES;
                4'd4: begin
                    if (col[5] ^ row[5]) begin
                        red_d = ONES;
                        grn_d = ONES;
                        blu_d = ONES;
                    end
                end
                4'd5: begin
                    red_d = {VIDEO_WIDTH{bar[2]}};
                    grn_d = {VIDEO_WIDTH{bar[1]}};
                    blu_d = {VIDEO_WIDTH{bar[0]}};
                end
                4'd6: begin
                    red_d = {VIDEO_WIDTH{on_border}};
                    grn_d = {VIDEO_WIDTH{on_border}};
                    blu_d = {VIDEO_WIDTH{on_border}};
                end
                4'd7: begin
                    red_d = {VIDEO_WIDTH{in_box}};
                    grn_d = {VIDEO_WIDTH{in_box}};
                    blu_d = {VIDEO_WIDTH{in_box}};
                end
                4'd8: begin
                    red_d = {VIDEO_WIDTH{scroll_bar[2]}};
                    grn_d = {VIDEO_WIDTH{scroll_bar[1]}};
                    blu_d = {VIDEO_WIDTH{scroll_bar[0]}};
                end
                4'd9: begin
                    red_d = grey;
                    grn_d = grey;
                    blu_d = grey;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            o_Red_Video <= '0;
            o_Grn_Video <= '0;
            o_Blu_Video <= '0;
        end else begin
            o_Red_Video <= red_d;
            o_Grn_Video <= grn_d;
            o_Blu_Video <= blu_d;
        end
    end

endmodule

// File: tb/tb_anim_pattern_gen.sv
// tb/tb_anim_pattern_gen.sv - directed self-checking bench for anim_pattern_gen

module tb_anim_pattern_gen;

    localparam int VW  = 3;
    localparam int TC  = 80;
    localparam int TR  = 52;
    localparam int AC  = 64;
    localparam int AR  = 48;
    localparam int BOX = 8;
    localparam int CF  = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [3:0]    i_pattern = '0;
    logic          i_auto = 1'b0;
    logic          i_hsync = 1'b0;
    logic          i_vsync = 1'b0;
    logic          o_hsync, o_vsync, o_frame_start;
    logic [VW-1:0] o_red, o_grn, o_blu;
    logic [3:0]    o_active_pattern;

    anim_pattern_gen #(
        .VIDEO_WIDTH(VW), .TOTAL_COLS(TC), .TOTAL_ROWS(TR), .ACTIVE_COLS(AC),
        .ACTIVE_ROWS(AR), .BOX_SIZE(BOX), .CYCLE_FRAMES(CF)
    ) dut (
        .i_Clk(clk), .i_Rst_L(rst_n), .i_Pattern(i_pattern), .i_Auto(i_auto),
        .i_HSync(i_hsync), .i_VSync(i_vsync), .o_HSync(o_hsync), .o_VSync(o_vsync),
        .o_Red_Video(o_red), .o_Grn_Video(o_grn), .o_Blu_Video(o_blu),
        .o_Active_Pattern(o_active_pattern), .o_Frame_Start(o_frame_start)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] pat;
        int         c;
        int         r;
        logic [8:0] rgb;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   pos   = 0;
    int   exp_auto[22] = '{0,1,1,2,2,3,3,4,4,5,5,6,6,7,7,8,8,9,9,1,1,2};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] rgb();
        return {23'b0, o_red, o_grn, o_blu};
    endfunction

    function automatic logic [31:0] all_outs();
        return {16'b0, o_hsync, o_vsync, o_frame_start, o_active_pattern, o_red, o_grn, o_blu};
    endfunction

    // Triangle wave 0..maxv..0 after n single steps starting at 0 going up.
    function automatic int tri_pos(input int n, input int maxv);
        int p;
        p = n % (2 * maxv);
        return (p <= maxv) ? p : 2 * maxv - p;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        pos += n;
    endtask

    // Returns on the negedge right after the detecting edge (counter at 0,0).
    task automatic start_frame();
        @(negedge clk);
        i_vsync = 1'b1;
        @(negedge clk);
        i_vsync = 1'b0;
        pos = 0;
    endtask

    // Pixel (c,r) is on the video outputs r*TC+c+1 cycles after start_frame.
    task automatic goto_px(input int c, input int r);
        int t;
        t = r * TC + c + 1;
        if (t > pos) tick(t - pos);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        tbl.push_back('{4'd1,  5,  3, 9'o700});
        tbl.push_back('{4'd1, 70,  3, 9'o000});
        tbl.push_back('{4'd2,  0,  0, 9'o070});
        tbl.push_back('{4'd3, 63, 47, 9'o007});
        tbl.push_back('{4'd3, 10, 49, 9'o000});
        tbl.push_back('{4'd0, 20,  2, 9'o000});
        tbl.push_back('{4'd4,  0,  0, 9'o000});
        tbl.push_back('{4'd4, 32,  0, 9'o777});
        tbl.push_back('{4'd4, 32, 32, 9'o000});
        tbl.push_back('{4'd4,  5, 33, 9'o777});
        tbl.push_back('{4'd5,  7,  2, 9'o000});
        tbl.push_back('{4'd5,  8,  2, 9'o007});
        tbl.push_back('{4'd5, 16,  1, 9'o070});
        tbl.push_back('{4'd5, 40,  1, 9'o707});
        tbl.push_back('{4'd5, 63,  1, 9'o777});
        tbl.push_back('{4'd5, 65,  1, 9'o000});
        tbl.push_back('{4'd6, 30,  0, 9'o777});
        tbl.push_back('{4'd6, 30,  1, 9'o777});
        tbl.push_back('{4'd6, 30,  2, 9'o000});
        tbl.push_back('{4'd6,  0,  3, 9'o777});
        tbl.push_back('{4'd6,  1,  3, 9'o777});
        tbl.push_back('{4'd6,  2,  3, 9'o000});
        tbl.push_back('{4'd6, 61,  3, 9'o000});
        tbl.push_back('{4'd6, 62,  3, 9'o777});
        tbl.push_back('{4'd6, 63,  3, 9'o777});
        tbl.push_back('{4'd6, 30, 45, 9'o000});
        tbl.push_back('{4'd6, 30, 46, 9'o777});
        tbl.push_back('{4'd6, 30, 47, 9'o777});
        tbl.push_back('{4'd6, 40, 48, 9'o000});
        tbl.push_back('{4'd9,  0,  5, 9'o000});
        tbl.push_back('{4'd9,  8,  5, 9'o111});
        tbl.push_back('{4'd9, 33,  5, 9'o444});
        tbl.push_back('{4'd9, 63,  5, 9'o777});
        tbl.push_back('{4'd9, 70,  5, 9'o000});
        tbl.push_back('{4'd10, 10, 2, 9'o000});
        tbl.push_back('{4'd15, 10, 2, 9'o000});

        // Reset state
        @(negedge clk);
        check("reset_outputs", all_outs(), 32'h0);
        rst_n = 1'b1;

        // Table: pattern colouring at chosen pixels
        foreach (tbl[i]) begin
            i_pattern = tbl[i].pat;
            start_frame();
            check($sformatf("active_pat[%0d]", i), 32'(o_active_pattern), 32'(tbl[i].pat));
            goto_px(tbl[i].c, tbl[i].r);
            check($sformatf("pixel[%0d] p%0d (%0d,%0d)", i, tbl[i].pat, tbl[i].c, tbl[i].r),
                  rgb(), {23'b0, tbl[i].rgb});
        end

        // Frame-start pulse width
        i_pattern = 4'd1;
        start_frame();
        check("frame_start_hi", 32'(o_frame_start), 32'd1);
        tick(1);
        check("frame_start_lo", 32'(o_frame_start), 32'd0);

        // Sync delay and alignment with the first active pixel
        @(negedge clk);
        i_hsync = 1'b1;
        @(negedge clk);
        check("hsync_d1", 32'(o_hsync), 32'd0);
        @(negedge clk);
        check("hsync_d2", 32'(o_hsync), 32'd1);
        i_hsync = 1'b0;
        @(negedge clk);
        check("hsync_fall_d1", 32'(o_hsync), 32'd1);
        @(negedge clk);
        check("hsync_fall_d2", 32'(o_hsync), 32'd0);
        @(negedge clk);
        i_vsync = 1'b1;
        @(negedge clk);
        check("vsync_d1", 32'(o_vsync), 32'd0);
        @(negedge clk);
        check("vsync_d2", 32'(o_vsync), 32'd1);
        check("vsync_first_pixel", rgb(), 32'o700);
        i_vsync = 1'b0;
        @(negedge clk);
        check("vsync_fall_d1", 32'(o_vsync), 32'd1);
        @(negedge clk);
        check("vsync_fall_d2", 32'(o_vsync), 32'd0);

        // Mid-frame pattern change waits for the next frame start
        i_pattern = 4'd1;
        start_frame();
        goto_px(5, 2);
        check("midframe_before", rgb(), 32'o700);
        i_pattern = 4'd3;
        goto_px(20, 4);
        check("midframe_after", rgb(), 32'o700);
        check("midframe_pat", 32'(o_active_pattern), 32'd1);
        goto_px(10, 47);
        check("midframe_last_row", rgb(), 32'o700);
        start_frame();
        check("newframe_pat", 32'(o_active_pattern), 32'd3);
        check("newframe_pulse", 32'(o_frame_start), 32'd1);
        goto_px(0, 0);
        check("newframe_pixel", rgb(), 32'o007);

        // Auto cycling from reset
        do_reset();
        i_auto = 1'b1;
        for (int k = 0; k < 22; k++) begin
            start_frame();
            check($sformatf("auto_seq[%0d]", k), 32'(o_active_pattern), 32'(exp_auto[k]));
        end
        // Manual out-of-range value, then re-enter auto
        i_auto = 1'b0;
        i_pattern = 4'd12;
        start_frame();
        check("manual_12", 32'(o_active_pattern), 32'd12);
        i_auto = 1'b1;
        start_frame();
        check("auto_enter_hold", 32'(o_active_pattern), 32'd12);
        start_frame();
        check("auto_12_to_1", 32'(o_active_pattern), 32'd1);
        i_auto = 1'b0;
        i_pattern = 4'd5;
        start_frame();
        check("auto_leave", 32'(o_active_pattern), 32'd5);

        // Bouncing box
        do_reset();
        begin
            int cps[6] = '{1, 40, 56, 57, 112, 113};
            int done;
            int bx, by;
            done = 0;
            i_pattern = 4'd7;
            foreach (cps[j]) begin
                repeat (cps[j] - done) start_frame();
                done = cps[j];
                bx = tri_pos(cps[j], AC - BOX);
                by = tri_pos(cps[j], AR - BOX);
                if (bx > 0) begin
                    goto_px(bx - 1, by);
                    check($sformatf("box%0d_left", cps[j]), rgb(), 32'o000);
                end
                goto_px(bx, by);
                check($sformatf("box%0d_tl", cps[j]), rgb(), 32'o777);
                goto_px(bx + BOX, by);
                check($sformatf("box%0d_right", cps[j]), rgb(), 32'o000);
                goto_px(bx + BOX - 1, by + BOX - 1);
                check($sformatf("box%0d_br", cps[j]), rgb(), 32'o777);
                goto_px(bx, by + BOX);
                check($sformatf("box%0d_below", cps[j]), rgb(), 32'o000);
            end
        end

        // Scrolling bars across frame_count values including the wrap
        do_reset();
        i_pattern = 4'd8;
        start_frame();
        goto_px(0, 0);
        check("scroll1_c0", rgb(), 32'o000);
        goto_px(6, 0);
        check("scroll1_c6", rgb(), 32'o007);
        repeat (27) start_frame();
        goto_px(0, 0);
        check("scroll28_c0", rgb(), 32'o777);
        goto_px(16, 0);
        check("scroll28_c16", rgb(), 32'o007);
        repeat (227) start_frame();
        goto_px(0, 0);
        check("scroll255_c0", rgb(), 32'o777);
        goto_px(2, 0);
        check("scroll255_c2", rgb(), 32'o000);
        start_frame();
        goto_px(0, 0);
        check("scroll256_c0", rgb(), 32'o000);
        goto_px(8, 0);
        check("scroll256_c8", rgb(), 32'o007);

        // Asynchronous reset mid-frame, then recovery
        i_pattern = 4'd1;
        i_hsync = 1'b1;
        start_frame();
        goto_px(10, 2);
        check("prereset_pixel", rgb(), 32'o700);
        check("prereset_hsync", 32'(o_hsync), 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_reset_outs", all_outs(), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        i_hsync = 1'b0;
        i_pattern = 4'd2;
        start_frame();
        check("postreset_pat", 32'(o_active_pattern), 32'd2);
        goto_px(3, 1);
        check("postreset_pixel", rgb(), 32'o070);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
